// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter sending start, DATA_W data bits LSB first, optional parity and 1-2 stop bits.
module uart_tx_frame #(
    parameter int CLK_DIV   = 8,
    parameter int DATA_W    = 8,
    parameter int PAR_MODE  = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              uart_txd
);
    localparam int CW = $clog2(CLK_DIV);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] idx, idx_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic par, par_n, busy_n, done_n, txd_n, wrap;
    assign wrap = cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            par      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            sh       <= sh_n;
            par      <= par_n;
            busy     <= busy_n;
            done     <= done_n;
            uart_txd <= txd_n;
        end
    end
    // Every wrap of the baud counter registers the next bit onto the line on the same edge.
    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        par_n   = par;
        busy_n  = busy;
        done_n  = 1'b0;
        txd_n   = uart_txd;
        case (state)
            IDLE: if (start && !busy) begin
                state_n = START;
                sh_n    = din;
                par_n   = (PAR_MODE == 2) ? ~^din : ^din;
                busy_n  = 1'b1;
                txd_n   = 1'b0;
            end
            START: if (wrap) begin
                state_n = DATA;
                txd_n   = sh[0];
                sh_n    = sh >> 1;
                idx_n   = '0;
            end
            DATA: if (wrap) begin
                if (idx == 4'(DATA_W - 1)) begin
                    idx_n   = '0;
                    state_n = (PAR_MODE != 0) ? PARITY : STOP;
                    txd_n   = (PAR_MODE != 0) ? par : 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                    txd_n = sh[0];
                    sh_n  = sh >> 1;
                end
            end
            PARITY: if (wrap) begin
                state_n = STOP;
                txd_n   = 1'b1;
            end
            STOP: if (wrap) begin
                if (idx == 4'(STOP_BITS - 1)) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench over four configurations; frames are hand-written bit strings, LSB first.
module tb_uart_tx_frame;
    typedef struct {
        int    inst;
        string s;
        int    gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] start;
    logic [7:0] din8 [3];
    logic [4:0] din5;
    wire  [3:0] busy, done, txd;

    exp_t q[$];
    exp_t cur[4];
    bit   active[4];
    int   cyc[4], errs[4], first_bad[4], last_done[4];
    int   gcyc = 0;
    int   n_cmp = 0, n_miss = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_DIV(8), .DATA_W(8), .PAR_MODE(0), .STOP_BITS(1)) u_a (
        .clk(clk), .n_rst(n_rst), .start(start[0]), .din(din8[0]),
        .busy(busy[0]), .done(done[0]), .uart_txd(txd[0]));
    uart_tx_frame #(.CLK_DIV(8), .DATA_W(8), .PAR_MODE(1), .STOP_BITS(1)) u_b (
        .clk(clk), .n_rst(n_rst), .start(start[1]), .din(din8[1]),
        .busy(busy[1]), .done(done[1]), .uart_txd(txd[1]));
    uart_tx_frame #(.CLK_DIV(8), .DATA_W(8), .PAR_MODE(2), .STOP_BITS(2)) u_c (
        .clk(clk), .n_rst(n_rst), .start(start[2]), .din(din8[2]),
        .busy(busy[2]), .done(done[2]), .uart_txd(txd[2]));
    uart_tx_frame #(.CLK_DIV(2), .DATA_W(5), .PAR_MODE(0), .STOP_BITS(1)) u_d (
        .clk(clk), .n_rst(n_rst), .start(start[3]), .din(din5),
        .busy(busy[3]), .done(done[3]), .uart_txd(txd[3]));

    function automatic int cd(int i);
        return (i == 3) ? 2 : 8;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each busy cycle is compared against the expected bit; frame summary checked on done.
    always @(negedge clk) begin
        gcyc++;
        for (int i = 0; i < 4; i++) begin
            if (!n_rst) begin
                active[i] = 1'b0;
            end else if (busy[i]) begin
                if (!active[i]) begin
                    active[i] = 1'b1;
                    cyc[i] = 0;
                    errs[i] = 0;
                    first_bad[i] = -1;
                    if (q.size() != 0 && q[0].inst == i) begin
                        cur[i] = q.pop_front();
                    end else begin
                        cur[i] = '{i, "", 0};
                        chk($sformatf("inst%0d_unexpected_frame", i), int'(busy[i]), 0);
                    end
                end
                chk($sformatf("inst%0d_done_while_busy", i), int'(done[i]), 0);
                if (cyc[i] / cd(i) < cur[i].s.len()) begin
                    if (txd[i] !== (cur[i].s[cyc[i] / cd(i)] == "1")) begin
                        if (errs[i] == 0) first_bad[i] = cyc[i];
                        errs[i]++;
                    end
                end else begin
                    errs[i]++;
                end
                cyc[i]++;
            end else begin
                chk($sformatf("inst%0d_idle_line", i), int'(txd[i]), 1);
                if (done[i]) begin
                    if (active[i]) begin
                        chk($sformatf("inst%0d_busy_cycles", i), cyc[i], cur[i].s.len() * cd(i));
                        chk($sformatf("inst%0d_line_bit_errors(first@%0d)", i, first_bad[i]), errs[i], 0);
                        if (cur[i].gap != 0)
                            chk($sformatf("inst%0d_done_spacing", i), gcyc - last_done[i], cur[i].gap);
                    end else begin
                        chk($sformatf("inst%0d_spurious_done", i), int'(done[i]), 0);
                    end
                    active[i] = 1'b0;
                    last_done[i] = gcyc;
                end
            end
        end
    end

    task automatic send(int i, logic [7:0] d, string s, int gap);
        @(negedge clk);
        if (i == 3) din5 = d[4:0];
        else din8[i] = d;
        start[i] = 1'b1;
        q.push_back('{i, s, gap});
        @(posedge clk);
        #1 start[i] = 1'b0;
    endtask

    task automatic wait_idle(int i);
        int t = 0;
        do begin
            @(negedge clk);
            #1 t++;
        end while ((q.size() != 0 || busy[i] || active[i]) && t < 3000);
        chk($sformatf("inst%0d_frame_complete", i), (q.size() != 0 || busy[i]) ? 1 : 0, 0);
    endtask

    task automatic check_quiet(string tag, int i);
        chk($sformatf("%s_txd%0d", tag, i), int'(txd[i]), 1);
        chk($sformatf("%s_busy%0d", tag, i), int'(busy[i]), 0);
        chk($sformatf("%s_done%0d", tag, i), int'(done[i]), 0);
    endtask

    initial begin
        n_rst = 1'b0;
        start = '0;
        for (int i = 0; i < 3; i++) din8[i] = '0;
        din5 = '0;
        for (int i = 0; i < 4; i++) last_done[i] = 0;
        repeat (3) @(negedge clk);
        #1 for (int i = 0; i < 4; i++) check_quiet("reset", i);
        @(negedge clk);
        n_rst = 1'b1;

        send(0, 8'hA5, "0101001011", 0);
        wait_idle(0);

        // A second request at cycle 20 of the frame must be ignored.
        send(0, 8'hA5, "0101001011", 0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        din8[0] = 8'h3C;
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_idle(0);

        send(1, 8'h07, "01110000011", 0);
        wait_idle(1);
        send(1, 8'h03, "01100000001", 0);
        wait_idle(1);
        send(2, 8'h07, "011100000011", 0);
        wait_idle(2);
        send(3, 8'h11, "0100011", 0);
        wait_idle(3);
        send(3, 8'h1F, "0111111", 0);
        wait_idle(3);

        // Held start: frames repeat with one idle cycle, done every 81 cycles.
        q.push_back('{0, "0010110101", 0});
        q.push_back('{0, "0010110101", 81});
        q.push_back('{0, "0010110101", 81});
        @(negedge clk);
        din8[0] = 8'h5A;
        start[0] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int t = 0;
            while (busy[0] && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("b2b_busy_released", int'(busy[0]), 0);
            @(posedge clk);
            #1;
        end
        start[0] = 1'b0;
        wait_idle(0);

        send(0, 8'hA5, "0101001011", 0);
        repeat (36) @(posedge clk);
        #2 n_rst = 1'b0;
        #1 check_quiet("midframe_reset", 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        din8[0] = 8'h00;
        start[0] = 1'b1;
        q.push_back('{0, "0000000001", 0});
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        chk("accept_after_release", int'(busy[0]), 1);
        wait_idle(0);

        chk("queue_left", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule
